// File: rtl/ls_chip_spike_gen_if.sv
// ls_chip_spike_gen_if: enable/probability/spike bundle for ls_chip_spike_gen; spike_cnt exists only under `LS_SPIKE_CNT_EN
interface ls_chip_spike_gen_if #(
    parameter int bit_chip = 6
);
    logic                en;
    logic [bit_chip-1:0] bit_to_chip;
    logic                request_z;
    logic [bit_chip-1:0] prob_q;
    logic                busy;
`ifdef LS_SPIKE_CNT_EN
    logic [15:0]         spike_cnt;
    modport master (output en, bit_to_chip, input request_z, prob_q, busy, spike_cnt);
    modport slave  (input en, bit_to_chip, output request_z, prob_q, busy, spike_cnt);
`else
    modport master (output en, bit_to_chip, input request_z, prob_q, busy);
    modport slave  (input en, bit_to_chip, output request_z, prob_q, busy);
`endif
endinterface

// File: rtl/ls_chip_spike_gen.sv
// ls_chip_spike_gen: LFSR-drawn stochastic spike emitter with delayed probability reload; `LS_SPIKE_CNT_EN adds a saturating spike_cnt
module ls_chip_spike_gen #(
    parameter int                     bit_chip      = 6,
    parameter int                     bit_lfsr      = 16,
    parameter logic [bit_lfsr-1:0]    lfsr_seed     = 16'hACE1,
    parameter int                     pw            = 4,
    parameter int                     r_main_to_low = 1000,
    parameter int                     load_delay    = 8,
    parameter int                     ref_ticks     = 2,
    parameter int                     init_prob     = 0
) (
    input logic                 clk_main,
    input logic                 rst,
    ls_chip_spike_gen_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_FIRE, S_LOAD, S_REF} state_t;
    localparam int cnt_a   = pw > load_delay ? pw : load_delay;
    localparam int cnt_max = cnt_a > ref_ticks ? cnt_a : ref_ticks;
    localparam int cw      = $clog2(cnt_max + 1);
    localparam int tw      = $clog2(r_main_to_low);
    localparam logic [cw-1:0] pw_last  = cw'(pw - 1);
    localparam logic [cw-1:0] ld_last  = cw'(load_delay - 1);
    localparam logic [cw-1:0] ref_last = cw'(ref_ticks > 0 ? ref_ticks - 1 : 0);
    state_t              state, state_n;
    logic [cw-1:0]       cnt, cnt_n;
    logic [tw-1:0]       tick_cnt;
    logic [bit_lfsr-1:0] lfsr, lfsr_n;
    logic [bit_chip-1:0] prob_r;
    logic                req_r, busy_r, tick, hit, load;
    assign tick   = tick_cnt == tw'(r_main_to_low - 1);
    assign lfsr_n = {lfsr[bit_lfsr-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign hit    = lfsr[bit_chip-1:0] < prob_r;
    assign bus.request_z = req_r;
    assign bus.prob_q    = prob_r;
    assign bus.busy      = busy_r;
    // cnt is shared: pulse cycles in S_FIRE, settle cycles in S_LOAD, ticks in S_REF
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        case (state)
            S_IDLE: begin
                state_n = (tick && bus.en && hit) ? S_FIRE : S_IDLE;
                cnt_n   = '0;
            end
            S_FIRE: begin
                state_n = cnt == pw_last ? S_LOAD : S_FIRE;
                cnt_n   = cnt == pw_last ? '0 : cnt + 1'b1;
            end
            S_LOAD: begin
                load    = cnt == ld_last;
                state_n = cnt != ld_last ? S_LOAD : (ref_ticks == 0 ? S_IDLE : S_REF);
                cnt_n   = cnt == ld_last ? '0 : cnt + 1'b1;
            end
            S_REF: begin
                state_n = (tick && cnt == ref_last) ? S_IDLE : S_REF;
                cnt_n   = !tick ? cnt : (cnt == ref_last ? '0 : cnt + 1'b1);
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end
    always_ff @(posedge clk_main) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            tick_cnt <= '0;
            lfsr     <= lfsr_seed;
            prob_r   <= bit_chip'(init_prob);
            req_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            lfsr     <= tick ? lfsr_n : lfsr;
            prob_r   <= load ? bus.bit_to_chip : prob_r;
            req_r    <= state_n == S_FIRE;
            busy_r   <= state_n != S_IDLE;
        end
    end
`ifdef LS_SPIKE_CNT_EN
    logic [15:0] spike_cnt_r;
    assign bus.spike_cnt = spike_cnt_r;
    always_ff @(posedge clk_main) begin
        if (rst)
            spike_cnt_r <= '0;
        else if (state_n == S_FIRE && !req_r && spike_cnt_r != 16'hFFFF)
            spike_cnt_r <= spike_cnt_r + 16'd1;
    end
`endif
endmodule

// File: tb/tb_ls_chip_spike_gen.sv
// tb_ls_chip_spike_gen: cycle-level schedule model plus directed literal checks for ls_chip_spike_gen
module tb_ls_chip_spike_gen;
    localparam int R  = 4;
    localparam int PW = 4;
    localparam int LD = 8;
    localparam int RT = 2;
    localparam int IP = 63;
    logic clk_main, rst;
    int   checks = 0, failures = 0;
    ls_chip_spike_gen_if #(.bit_chip(6)) bus ();
    ls_chip_spike_gen #(
        .bit_chip(6), .bit_lfsr(16), .lfsr_seed(16'hACE1), .pw(PW),
        .r_main_to_low(R), .load_delay(LD), .ref_ticks(RT), .init_prob(IP)
    ) dut (
        .clk_main(clk_main),
        .rst(rst),
        .bus(bus)
    );
    initial begin
        clk_main = 1'b0;
        forever #5 clk_main = ~clk_main;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction
    // model works on absolute cycle numbers: a hit fixes the rise, latch and next-drawable cycle
    int          m_k, rise, latch, free_from, first_t;
    logic [15:0] m_lfsr, m_spk;
    logic [5:0]  m_prob;
    logic        m_req, m_busy, m_valid = 1'b0, m_tick;
    always @(posedge clk_main) begin
        if (rst) begin
            m_k = 0; m_lfsr = 16'hACE1; m_prob = 6'(IP); rise = -1; latch = -1;
            free_from = 0; m_req = 1'b0; m_busy = 1'b0; m_spk = '0; m_valid = 1'b1;
        end else begin
            m_tick = (m_k % R) == R - 1;
            if (m_tick && m_k >= free_from && bus.en && m_lfsr[5:0] < m_prob) begin
                rise  = m_k + 1;
                latch = m_k + PW + LD;
                first_t = latch + 1 + ((R - 1 - ((latch + 1) % R)) + R) % R;
                free_from = RT == 0 ? latch + 1 : first_t + (RT - 1) * R + 1;
                if (m_spk != 16'hFFFF) m_spk = m_spk + 16'd1;
            end
            if (m_k == latch) m_prob = bus.bit_to_chip;
            if (m_tick) m_lfsr = lfsr_step(m_lfsr);
            m_k++;
            m_req  = rise >= 0 && m_k >= rise && m_k < rise + PW;
            m_busy = rise >= 0 && m_k >= rise && m_k < free_from;
        end
    end
    always @(negedge clk_main) begin
        if (m_valid) begin
            chk("model_request_z", 32'(bus.request_z), 32'(m_req));
            chk("model_busy", 32'(bus.busy), 32'(m_busy));
            chk("model_prob_q", 32'(bus.prob_q), 32'(m_prob));
`ifdef LS_SPIKE_CNT_EN
            chk("model_spike_cnt", 32'(bus.spike_cnt), 32'(m_spk));
`endif
        end
    end
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk_main);
        rst = 1'b0;
    endtask
    task automatic wait_rise(output int r);
        for (int i = 0; i < 200 && !bus.request_z; i++) @(negedge clk_main);
        chk("rise_timeout", 32'(bus.request_z), 32'd1);
        r = m_k;
    endtask
    initial begin
        int high_cnt, rise_at, prob_at, viol, rises, r;
        logic prev;
        bus.en = 1'b0;
        bus.bit_to_chip = 6'h2A;
        do_reset(3);
        chk("reset_request_z", 32'(bus.request_z), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_prob_q", 32'(bus.prob_q), 32'd63);
        bus.en = 1'b1;
        high_cnt = 0; rise_at = -1; prob_at = -1; viol = 0; prev = 1'b0;
        while (m_k < 60) begin
            @(negedge clk_main);
            if (bus.request_z && m_k < 16) high_cnt++;
            if (bus.request_z && rise_at < 0) rise_at = m_k;
            if (prob_at < 0 && bus.prob_q == 6'h15) prob_at = m_k;
            if (m_k >= 16 && m_k <= 24 && bus.request_z) viol++;
            if (bus.request_z && !prev && m_k > 24) chk("rise_after_tick", 32'((m_k - 1) % R), 32'(R - 1));
            if (m_k == 4) chk("lfsr_1_shift", 32'(dut.lfsr), 32'h59C3);
            if (m_k == 8) chk("lfsr_2_shift", 32'(dut.lfsr), 32'hB387);
            if (m_k == 12) chk("lfsr_3_shift", 32'(dut.lfsr), 32'h670F);
            if (m_k == 15) chk("prob_before_latch", 32'(bus.prob_q), 32'd63);
            prev = bus.request_z;
            bus.bit_to_chip = (m_k == 15) ? 6'h15 : 6'h2A;
        end
        chk("first_rise_cycle", 32'(rise_at), 32'd4);
        chk("pulse_width", 32'(high_cnt), 32'd4);
        chk("rise_to_load", 32'(prob_at - rise_at), 32'd12);
        chk("refractory_quiet", 32'(viol), 32'd0);
        do_reset(2);
        bus.en = 1'b0;
        rises = 0; prev = 1'b0;
        repeat (100 * R) begin
            @(negedge clk_main);
            if (bus.request_z && !prev) rises++;
            prev = bus.request_z;
        end
        chk("en_low_no_spike", 32'(rises), 32'd0);
        bus.en = 1'b1;
        bus.bit_to_chip = 6'h00;
        wait_rise(r);
        while (m_k < r + PW + 1) @(negedge clk_main);
        bus.en = 1'b0;
        chk("en_drop_in_load_busy", 32'(bus.busy), 32'd1);
        while (m_k < r + PW + LD - 1) @(negedge clk_main);
        chk("en_drop_prob_hold", 32'(bus.prob_q), 32'd63);
        @(negedge clk_main);
        chk("en_drop_latch", 32'(bus.prob_q), 32'd0);
        bus.en = 1'b1;
        rises = 0; prev = 1'b0;
        repeat (2000 * R) begin
            @(negedge clk_main);
            if (bus.request_z && !prev) rises++;
            prev = bus.request_z;
        end
        chk("zero_prob_no_spike", 32'(rises), 32'd0);
        chk("lfsr_after_run", 32'(dut.lfsr), 32'(m_lfsr));
        bus.bit_to_chip = 6'h2A;
        do_reset(2);
        wait_rise(r);
        @(negedge clk_main);
        chk("mid_pulse_high", 32'(bus.request_z), 32'd1);
        rst = 1'b1;
        @(negedge clk_main);
        rst = 1'b0;
        chk("mid_reset_request_z", 32'(bus.request_z), 32'd0);
        chk("mid_reset_busy", 32'(bus.busy), 32'd0);
        chk("mid_reset_prob_q", 32'(bus.prob_q), 32'd63);
        chk("mid_reset_lfsr", 32'(dut.lfsr), 32'hACE1);
        repeat (20) @(negedge clk_main);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
